// File: rtl/bb_ram_tx_reader.sv
// Packet-buffer RAM reader: fetches a byte range from the 32-bit buffer RAM and
// streams it out one byte per clock over a valid/ready interface.
module bb_ram_tx_reader #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned LEN_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  byte_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_addr_q, word_addr_d;
    logic [LEN_W-1:0]   words_left_q, words_left_d;
    logic [LEN_W-1:0]   bytes_left_q, bytes_left_d;
    logic [1:0]         lane_q, lane_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [31:0]        buf_q [2];

    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W:0]     span;
    logic [LEN_W-1:0]   words_total;
    logic               issue;
    logic               push;
    logic               pop;
    logic               xfer;
    logic [31:0]        cur_word;
    logic [7:0]         cur_byte;

    always_comb begin
        len_clamped = (byte_len > MaxLen) ? MaxLen : byte_len;
        // Words touched = ceil((first lane + length) / 4).
        span        = {1'b0, len_clamped} + (LEN_W+1)'(start_addr[1:0]) + (LEN_W+1)'(3);
        words_total = LEN_W'(span >> 2);
    end

    // Occupied entries plus the in-flight read may never exceed the 2-entry buffer.
    assign issue = (state_q == StRun) && (words_left_q != '0)
                && ((3'(count_q) + 3'(inflight_q)) < 3'd2);
    assign push  = inflight_q;

    assign cur_word  = buf_q[rd_ptr_q];
    assign cur_byte  = cur_word[{lane_q, 3'b000} +: 8];
    assign out_valid = (state_q == StRun) && (count_q != 2'd0);
    assign out_data  = out_valid ? cur_byte : 8'h00;
    assign out_last  = out_valid && (bytes_left_q == LEN_W'(1));
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && ((lane_q == 2'd3) || (bytes_left_q == LEN_W'(1)));

    assign ram_en    = issue;
    assign ram_addr  = issue ? word_addr_q : '0;
    assign ram_we    = 4'b0000;
    assign ram_wdata = 32'h0000_0000;

    always_comb begin
        state_d      = state_q;
        word_addr_d  = word_addr_q;
        words_left_d = words_left_q;
        bytes_left_d = bytes_left_q;
        lane_d       = lane_q;
        inflight_d   = issue;
        count_d      = count_q + 2'(push) - 2'(pop);
        wr_ptr_d     = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d     = pop ? ~rd_ptr_q : rd_ptr_q;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_clamped == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d      = StRun;
                        word_addr_d  = start_addr[ADDR_W-1:2];
                        words_left_d = words_total;
                        bytes_left_d = len_clamped;
                        lane_d       = start_addr[1:0];
                        count_d      = 2'd0;
                        wr_ptr_d     = 1'b0;
                        rd_ptr_d     = 1'b0;
                    end
                end
            end
            StRun: begin
                busy = 1'b1;
                if (issue) begin
                    word_addr_d  = word_addr_q + WORD_W'(1);
                    words_left_d = words_left_q - LEN_W'(1);
                end
                if (xfer) begin
                    bytes_left_d = bytes_left_q - LEN_W'(1);
                    // Lane wraps 3 -> 0, which is where every following word starts.
                    lane_d       = lane_q + 2'd1;
                    if (bytes_left_q == LEN_W'(1)) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            word_addr_q  <= '0;
            words_left_q <= '0;
            bytes_left_q <= '0;
            lane_q       <= 2'd0;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_addr_q  <= word_addr_d;
            words_left_q <= words_left_d;
            bytes_left_q <= bytes_left_d;
            lane_q       <= lane_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Data storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= ram_rdata;
        end
    end

endmodule
